mem_scan_burst: RTL and testbench

- Scan-side memory access engine that sits between the core SRAM port and the macro, next to the scan chain.
- Extends single-shot scan access to multi-word bursts: auto-incrementing address, programmable length, read/write/pattern modes, and a busy/done/overrun status.
- An optional read signature is available.
- The core path passes straight through whenever mem_use_scan is low.

---
 rtl/mem_scan_pkg.sv | 22 ++
 rtl/mem_scan_toggle_sync.sv | 31 +++
 rtl/mem_scan_burst.sv | 167 ++++++++++++++++
 tb/tb_mem_scan_burst.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_scan_pkg.sv
// Shared definitions for the scan-side memory burst engine: mode encodings,
// FSM state type and the default signature polynomial.
package mem_scan_pkg;

  localparam logic [1:0] MODE_READ     = 2'b00;
  localparam logic [1:0] MODE_WR_CONST = 2'b01;
  localparam logic [1:0] MODE_WR_INC   = 2'b10;
  localparam logic [1:0] MODE_READ_ALT = 2'b11;

  localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  function automatic logic mode_is_read(input logic [1:0] mode);
    return (mode == MODE_READ) || (mode == MODE_READ_ALT);
  endfunction

endpackage

// File: rtl/mem_scan_toggle_sync.sv
// Toggle-request synchronizer: SYNC_STAGES flops, a history flop and a
// registered edge pulse. Reusable by any scan wrapper taking toggle requests.
module mem_scan_toggle_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_toggle,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
      r_hist <= r_sync[SYNC_STAGES-1];
      // Registered pulse keeps the edge glitch-free toward the FSM.
      r_edge <= r_sync[SYNC_STAGES-1] ^ r_hist;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/mem_scan_burst.sv
// Scan-side multi-word burst engine in front of an SRAM macro; core path is
// passed through when mem_use_scan is low. Signature register: MEM_SCAN_MISR_EN.
//
// state | meaning
// IDLE  | waiting for an accepted trigger edge, macro deselected
// RUN   | one access per cycle at base+index
// DRAIN | capture of the final read word, then back to IDLE
module mem_scan_burst
  import mem_scan_pkg::*;
#(
  parameter int                  ADDR_BITS   = 16,
  parameter int                  DQ_BITS     = 32,
  parameter int                  BW_BITS     = 4,
  parameter int                  LEN_BITS    = 8,
  parameter int                  SYNC_STAGES = 3,
  parameter logic [DQ_BITS-1:0]  MISR_POLY   = DQ_BITS'(MISR_POLY_DEFAULT)
) (
  input  logic                 CLK,
  input  logic                 mem_scan_reset_n,
  input  logic                 mem_use_scan,
  input  logic                 scan_mem_sel,
  input  logic                 mem_trigger,
  input  logic [ADDR_BITS-1:0] scan_addr,
  input  logic [DQ_BITS-1:0]   scan_d,
  input  logic [LEN_BITS-1:0]  scan_len,
  input  logic [1:0]           scan_mode,
  input  logic [ADDR_BITS-1:0] A,
  input  logic [DQ_BITS-1:0]   D,
  input  logic [BW_BITS-1:0]   BWE_n,
  input  logic                 CE_n,
  input  logic [DQ_BITS-1:0]   Q,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DQ_BITS-1:0]   mem_d,
  output logic [BW_BITS-1:0]   mem_bwen_n,
  output logic                 mem_cen_n,
  output logic [DQ_BITS-1:0]   scan_q,
  output logic [DQ_BITS-1:0]   scan_sig,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic                 scan_overrun
);

  scan_state_e r_state, w_state_nxt;

  logic [ADDR_BITS-1:0] r_base;
  logic [DQ_BITS-1:0]   r_d;
  logic [LEN_BITS-1:0]  r_len;
  logic [LEN_BITS-1:0]  r_idx;
  logic [1:0]           r_mode;
  logic                 r_rd_pend;
  logic [DQ_BITS-1:0]   r_q;
  logic                 r_done;
  logic                 r_overrun;

  logic w_edge;
  logic w_accept;
  logic w_last;
  logic w_is_read;

  mem_scan_toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (CLK),
    .rst_n    (mem_scan_reset_n),
    .i_toggle (mem_trigger),
    .o_edge   (w_edge)
  );

  assign w_accept  = w_edge & scan_mem_sel & mem_use_scan & (r_state == IDLE);
  assign w_last    = (r_idx == r_len);
  assign w_is_read = mode_is_read(r_mode);

  always_ff @(posedge CLK or negedge mem_scan_reset_n) begin
    if (!mem_scan_reset_n) r_state <= IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN: begin
        if (!mem_use_scan) w_state_nxt = IDLE;
        else if (w_last)   w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge mem_scan_reset_n) begin
    if (!mem_scan_reset_n) begin
      r_base    <= '0;
      r_d       <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_mode    <= MODE_READ;
      r_rd_pend <= 1'b0;
      r_q       <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base <= scan_addr;
        r_d    <= scan_d;
        r_len  <= scan_len;
        r_mode <= scan_mode;
        r_idx  <= '0;
      end else if ((r_state == RUN) && mem_use_scan && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end

      // Q belongs to the access issued one cycle earlier.
      r_rd_pend <= (r_state == RUN) && mem_use_scan && w_is_read;
      if (r_rd_pend) r_q <= Q;

      // An abort during the final DRAIN cycle suppresses completion.
      if ((r_state == DRAIN) && mem_use_scan) r_done <= ~r_done;

      if (w_accept)
        r_overrun <= 1'b0;
      else if (w_edge && scan_mem_sel && (r_state != IDLE))
        r_overrun <= 1'b1;
    end
  end

`ifdef MEM_SCAN_MISR_EN
  logic [DQ_BITS-1:0] r_sig;

  always_ff @(posedge CLK or negedge mem_scan_reset_n) begin
    if (!mem_scan_reset_n) begin
      r_sig <= '0;
    end else if (w_accept && mode_is_read(scan_mode)) begin
      r_sig <= '0;
    end else if (r_rd_pend) begin
      r_sig <= {r_sig[DQ_BITS-2:0], 1'b0}
             ^ (r_sig[DQ_BITS-1] ? MISR_POLY : '0)
             ^ Q;
    end
  end

  assign scan_sig = r_sig;
`else
  logic w_unused_poly;
  assign w_unused_poly = ^MISR_POLY;
  assign scan_sig      = '0;
`endif

  always_comb begin
    mem_addr   = A;
    mem_d      = D;
    mem_bwen_n = BWE_n;
    mem_cen_n  = CE_n;
    if (mem_use_scan) begin
      mem_addr   = r_base + ADDR_BITS'(r_idx);
      mem_d      = (r_mode == MODE_WR_INC) ? (r_d + DQ_BITS'(r_idx)) : r_d;
      mem_bwen_n = w_is_read ? '1 : '0;
      mem_cen_n  = (r_state != RUN);
    end
  end

  assign scan_q       = r_q;
  assign scan_busy    = (r_state != IDLE);
  assign scan_done    = r_done;
  assign scan_overrun = r_overrun;

endmodule

// File: tb/tb_mem_scan_burst.sv
// Self-checking bench for mem_scan_burst: directed scenarios plus random
// bursts against a word-level burst model and a behavioural SRAM.
module tb_mem_scan_burst;

  logic        CLK = 1'b0;
  logic        mem_scan_reset_n;
  logic        mem_use_scan;
  logic        scan_mem_sel;
  logic        mem_trigger;
  logic [15:0] scan_addr;
  logic [31:0] scan_d;
  logic [7:0]  scan_len;
  logic [1:0]  scan_mode;
  logic [15:0] A;
  logic [31:0] D;
  logic [3:0]  BWE_n;
  logic        CE_n;
  logic [31:0] Q;
  logic [15:0] mem_addr;
  logic [31:0] mem_d;
  logic [3:0]  mem_bwen_n;
  logic        mem_cen_n;
  logic [31:0] scan_q;
  logic [31:0] scan_sig;
  logic        scan_busy;
  logic        scan_done;
  logic        scan_overrun;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] ram     [logic [15:0]];
  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] q_reg = 32'h0;

  logic        exp_done = 1'b0;
  logic        exp_ovr  = 1'b0;
  logic [31:0] exp_q    = 32'h0;
  logic [31:0] exp_sig  = 32'h0;

  always #5 CLK = ~CLK;

  mem_scan_burst dut (
    .CLK              (CLK),
    .mem_scan_reset_n (mem_scan_reset_n),
    .mem_use_scan     (mem_use_scan),
    .scan_mem_sel     (scan_mem_sel),
    .mem_trigger      (mem_trigger),
    .scan_addr        (scan_addr),
    .scan_d           (scan_d),
    .scan_len         (scan_len),
    .scan_mode        (scan_mode),
    .A                (A),
    .D                (D),
    .BWE_n            (BWE_n),
    .CE_n             (CE_n),
    .Q                (Q),
    .mem_addr         (mem_addr),
    .mem_d            (mem_d),
    .mem_bwen_n       (mem_bwen_n),
    .mem_cen_n        (mem_cen_n),
    .scan_q           (scan_q),
    .scan_sig         (scan_sig),
    .scan_busy        (scan_busy),
    .scan_done        (scan_done),
    .scan_overrun     (scan_overrun)
  );

  // Behavioural SRAM macro: read data appears the cycle after the access.
  always @(posedge CLK) begin
    if (!mem_cen_n) begin
      if (mem_bwen_n == 4'hF) q_reg <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
      else if (mem_bwen_n == 4'h0) ram[mem_addr] = mem_d;
    end
  end
  assign Q = q_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] q);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ q;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_done"}, {31'h0, scan_done}, {31'h0, exp_done});
    check({tag, "_ovr"},  {31'h0, scan_overrun}, {31'h0, exp_ovr});
    check({tag, "_q"},    scan_q, exp_q);
`ifdef MEM_SCAN_MISR_EN
    check({tag, "_sig"},  scan_sig, exp_sig);
`else
    check({tag, "_sig"},  scan_sig, 32'h0);
`endif
  endtask

  // Called just after a negedge; core CE_n is deasserted again before the posedge.
  task automatic passthru_check(input string tag);
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    a = 16'($urandom);
    d = $urandom;
    b = 4'($urandom);
    A = a; D = d; BWE_n = b; CE_n = 1'b0;
    #1;
    check({tag, "_addr"}, {16'h0, mem_addr}, {16'h0, a});
    check({tag, "_d"},    mem_d, d);
    check({tag, "_bwen"}, {28'h0, mem_bwen_n}, {28'h0, b});
    check({tag, "_cen"},  {31'h0, mem_cen_n}, 32'h0);
    CE_n = 1'b1;
  endtask

  // One burst from trigger to completion; *_at >= 0 inject an overrun toggle,
  // a use_scan abort or a reset at that access index.
  task automatic burst(input logic [15:0] a, input int len, input logic [1:0] m,
                       input logic [31:0] d, input int ovr_at, input int abort_at,
                       input int rst_at);
    int          lat;
    bit          rd;
    logic [15:0] ea;
    logic [31:0] ed;
    rd = (m == 2'b00) || (m == 2'b11);
    @(negedge CLK);
    scan_addr = a; scan_len = 8'(len); scan_mode = m; scan_d = d; scan_mem_sel = 1'b1;
    mem_trigger = ~mem_trigger;
    lat = 0;
    while (lat < 20) begin
      @(negedge CLK);
      lat++;
      if (!mem_cen_n) break;
    end
    check("latency", 32'(lat), 32'd5);
    if (lat != 5) return;
    exp_ovr = 1'b0;
    if (rd) exp_sig = 32'h0;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == rst_at) begin
        mem_scan_reset_n = 1'b0;
        mem_trigger = 1'b0;
        #1;
        exp_done = 1'b0; exp_ovr = 1'b0; exp_q = 32'h0; exp_sig = 32'h0;
        check("rst_busy", {31'h0, scan_busy}, 32'h0);
        check("rst_cen",  {31'h0, mem_cen_n}, 32'h1);
        check_status("rst");
        @(negedge CLK);
        mem_scan_reset_n = 1'b1;
        return;
      end
      ea = a + 16'(i);
      ed = (m == 2'b10) ? d + 32'(i) : d;
      check("acc_cen",  {31'h0, mem_cen_n}, 32'h0);
      check("acc_addr", {16'h0, mem_addr}, {16'h0, ea});
      check("acc_d",    mem_d, ed);
      check("acc_bwen", {28'h0, mem_bwen_n}, rd ? 32'hF : 32'h0);
      check("acc_busy", {31'h0, scan_busy}, 32'h1);
      if (i == abort_at) begin
        mem_use_scan = 1'b0;
        passthru_check("abort");
        @(negedge CLK);
        check("abort_busy", {31'h0, scan_busy}, 32'h0);
        check_status("abort");
        mem_use_scan = 1'b1;
        #1;
        check("abort_cen", {31'h0, mem_cen_n}, 32'h1);
        return;
      end
      if (rd) begin
        exp_q   = ref_rd(ea);
        exp_sig = misr(exp_sig, exp_q);
      end else begin
        ref_mem[ea] = ed;
      end
      if (i == ovr_at) begin
        mem_trigger = ~mem_trigger;
        exp_ovr = 1'b1;
      end
    end
    @(negedge CLK);
    check("drain_cen",  {31'h0, mem_cen_n}, 32'h1);
    check("drain_busy", {31'h0, scan_busy}, 32'h1);
    @(negedge CLK);
    exp_done = ~exp_done;
    check("idle_busy", {31'h0, scan_busy}, 32'h0);
    check_status("end");
  endtask

  initial begin
    mem_scan_reset_n = 1'b0;
    mem_use_scan = 1'b1; scan_mem_sel = 1'b1; mem_trigger = 1'b0;
    scan_addr = '0; scan_d = '0; scan_len = '0; scan_mode = '0;
    A = '0; D = '0; BWE_n = '1; CE_n = 1'b1;
    #1;
    check("reset_busy", {31'h0, scan_busy}, 32'h0);
    check("reset_cen",  {31'h0, mem_cen_n}, 32'h1);
    check_status("reset");
    repeat (3) @(negedge CLK);
    mem_scan_reset_n = 1'b1;

    mem_use_scan = 1'b0;
    @(negedge CLK);
    passthru_check("pass");
    mem_use_scan = 1'b1;

    burst(16'h0010, 3, 2'b01, 32'hA5A5A5A5, -1, -1, -1);
    burst(16'hFFFE, 3, 2'b10, 32'hFFFFFFFE, -1, -1, -1);
    burst(16'hFFFE, 3, 2'b00, 32'h0, -1, -1, -1);
    check("readback_q", scan_q, 32'h00000001);
    burst(16'h0010, 3, 2'b11, 32'h0, -1, -1, -1);

    burst(16'h0000, 255, 2'b00, 32'h0, 20, -1, -1);
    burst(16'h0010, 0, 2'b00, 32'h0, -1, -1, -1);

    burst(16'h0200, 7, 2'b01, 32'h12345678, -1, 2, -1);
    burst(16'h0200, 7, 2'b00, 32'h0, -1, -1, -1);

    @(negedge CLK);
    scan_mem_sel = 1'b0;
    mem_trigger = ~mem_trigger;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("nosel_cen", {31'h0, mem_cen_n}, 32'h1);
    end
    check("nosel_busy", {31'h0, scan_busy}, 32'h0);
    check_status("nosel");
    scan_mem_sel = 1'b1;

    burst(16'h0300, 15, 2'b10, 32'h00000100, -1, -1, 5);
    burst(16'h0400, 2, 2'b01, 32'hCAFEF00D, -1, -1, -1);
    burst(16'h0300, 15, 2'b00, 32'h0, -1, -1, -1);

    for (int n = 0; n < 30; n++) begin
      burst(16'h0100 + 16'($urandom_range(0, 31)), $urandom_range(0, 15),
            2'($urandom_range(0, 3)), $urandom, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
